// File: rtl/hpdcache_pkg.sv
// Shared HPDcache definitions used by the memory-side write responder:
// the cache configuration record, the memory command / atomic / error
// encodings and the memory request, write-data and write-response payloads.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH = 32;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 64;
  localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 4;

  typedef struct packed {
    int unsigned memAddrWidth;
    int unsigned memDataWidth;
    int unsigned memIdWidth;
  } hpdcache_user_cfg_t;

  typedef struct packed {
    hpdcache_user_cfg_t u;
  } hpdcache_cfg_t;

  localparam hpdcache_cfg_t HPDCACHE_CFG_DEFAULT = '{
    u: '{memAddrWidth: HPDCACHE_MEM_ADDR_WIDTH,
         memDataWidth: HPDCACHE_MEM_DATA_WIDTH,
         memIdWidth:   HPDCACHE_MEM_ID_WIDTH}
  };

  typedef enum logic [1:0] {
    HPDCACHE_MEM_READ   = 2'b00,
    HPDCACHE_MEM_WRITE  = 2'b01,
    HPDCACHE_MEM_ATOMIC = 2'b10
  } hpdcache_mem_command_e;

  typedef enum logic [3:0] {
    HPDCACHE_MEM_ATOMIC_ADD  = 4'b0000,
    HPDCACHE_MEM_ATOMIC_CLR  = 4'b0001,
    HPDCACHE_MEM_ATOMIC_SET  = 4'b0010,
    HPDCACHE_MEM_ATOMIC_SWAP = 4'b0110
  } hpdcache_mem_atomic_e;

  typedef enum logic [1:0] {
    HPDCACHE_MEM_RESP_OK  = 2'b00,
    HPDCACHE_MEM_RESP_NOK = 2'b10
  } hpdcache_mem_error_e;

  typedef logic [HPDCACHE_MEM_ID_WIDTH-1:0] hpdcache_mem_id_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [7:0]                         mem_req_len;
    logic [2:0]                         mem_req_size;
    hpdcache_mem_id_t                   mem_req_id;
    hpdcache_mem_command_e              mem_req_command;
    hpdcache_mem_atomic_e               mem_req_atomic;
    logic                               mem_req_cacheable;
  } hpdcache_mem_req_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0]   mem_req_w_data;
    logic [HPDCACHE_MEM_DATA_WIDTH/8-1:0] mem_req_w_be;
    logic                                 mem_req_w_last;
  } hpdcache_mem_req_w_t;

  typedef struct packed {
    hpdcache_mem_error_e mem_resp_w_error;
    hpdcache_mem_id_t    mem_resp_w_id;
    logic                mem_resp_w_is_atomic;
  } hpdcache_mem_resp_w_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO used as a small ordered queue.
// Ports: w_i/wok_o/wdata_i push side (push only when wok_o=1),
//        r_i/rok_o/rdata_o pop side (rdata_o valid while rok_o=1).
// Handshake: a push happens on w_i & wok_o, a pop on r_i & rok_o, both at
// the rising edge. wok_o depends only on fullness, so a full FIFO refuses a
// push even when a pop happens in the same cycle.
// With FEEDTHROUGH=0 a pushed entry becomes readable the cycle after the push.
module hpdcache_fifo_reg #(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter bit          FEEDTHROUGH = 1'b0,
  parameter type         fifo_data_t = logic
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       w_i,
  output logic       wok_o,
  input  fifo_data_t wdata_i,
  input  logic       r_i,
  output logic       rok_o,
  output fifo_data_t rdata_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fifo_data_t      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            empty, full, bypass, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  // Feedthrough lets a push into an empty FIFO be read in the same cycle.
  assign bypass  = FEEDTHROUGH && empty && w_i;
  assign wok_o   = ~full;
  assign rok_o   = ~empty | bypass;
  assign rdata_o = bypass ? wdata_i : mem_q[rptr_q];
  assign push    = w_i & ~full & ~(bypass & r_i);
  assign pop     = r_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: rtl/hpdcache_mem_write_responder.sv
// Memory-side responder for HPDcache write transactions. Accepts a write
// request (metadata), then a stream of data flits terminated by
// mem_req_w_last; each flit of a WRITE is forwarded to a backing store and
// every transaction returns one response through a registered queue.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   mem_req_write_*                    request metadata channel (ready in IDLE)
//   mem_req_write_data_*               write data flit channel
//   mem_resp_write_*                   write response channel
//   store_we_o/store_ready_i           backing-store strobe and acceptance
//   store_addr_o/wdata_o/be_o          byte address, data, byte enables
//   dbg_state_o                        0 = IDLE, 1 = DATA
// Handshakes: every channel transfers on valid & ready at the rising edge;
// valid never depends on ready, and payloads are held while valid & ~ready.
module hpdcache_mem_write_responder #(
  parameter hpdcache_pkg::hpdcache_cfg_t HPDcacheCfg = hpdcache_pkg::HPDCACHE_CFG_DEFAULT,
  parameter type hpdcache_mem_id_t     = hpdcache_pkg::hpdcache_mem_id_t,
  parameter type hpdcache_mem_req_t    = hpdcache_pkg::hpdcache_mem_req_t,
  parameter type hpdcache_mem_req_w_t  = hpdcache_pkg::hpdcache_mem_req_w_t,
  parameter type hpdcache_mem_resp_w_t = hpdcache_pkg::hpdcache_mem_resp_w_t,
  parameter int unsigned RespFifoDepth = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      mem_req_write_valid_i,
  output logic                                      mem_req_write_ready_o,
  input  hpdcache_mem_req_t                         mem_req_write_i,
  input  logic                                      mem_req_write_data_valid_i,
  output logic                                      mem_req_write_data_ready_o,
  input  hpdcache_mem_req_w_t                       mem_req_write_data_i,
  output logic                                      mem_resp_write_valid_o,
  input  logic                                      mem_resp_write_ready_i,
  output hpdcache_mem_resp_w_t                      mem_resp_write_o,
  output logic                                      store_we_o,
  input  logic                                      store_ready_i,
  output logic [HPDcacheCfg.u.memAddrWidth-1:0]     store_addr_o,
  output logic [HPDcacheCfg.u.memDataWidth-1:0]     store_wdata_o,
  output logic [HPDcacheCfg.u.memDataWidth/8-1:0]   store_be_o,
  output logic                                      dbg_state_o
);

  localparam int unsigned AddrW = HPDcacheCfg.u.memAddrWidth;
  localparam int unsigned DataW = HPDcacheCfg.u.memDataWidth;
  localparam int unsigned CntW  = 8;
  localparam logic [AddrW-1:0] FlitBytes = AddrW'(DataW / 8);

  typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_e;

  state_e                              state_q;
  logic [AddrW-1:0]                    base_q;
  hpdcache_mem_id_t                    id_q;
  hpdcache_pkg::hpdcache_mem_command_e cmd_q;
  hpdcache_pkg::hpdcache_mem_atomic_e  atomic_q;
  logic [CntW-1:0]                     cnt_q, cnt_d;

  logic meta_fire, flit_last, flit_fire, fifo_wok;
  hpdcache_mem_resp_w_t resp_wdata;

  assign mem_req_write_ready_o = (state_q == ST_IDLE);
  assign meta_fire  = mem_req_write_valid_i & mem_req_write_ready_o;
  assign flit_last  = mem_req_write_data_i.mem_req_w_last;

  // The last flit is only taken when its response has a queue slot, so a
  // full queue back-pressures the data channel instead of dropping a response.
  assign mem_req_write_data_ready_o = (state_q == ST_DATA) & store_ready_i &
                                      (~flit_last | fifo_wok);
  assign flit_fire  = mem_req_write_data_valid_i & mem_req_write_data_ready_o;

  assign store_we_o    = flit_fire & (cmd_q == hpdcache_pkg::HPDCACHE_MEM_WRITE);
  assign store_addr_o  = base_q + AddrW'(cnt_q) * FlitBytes;
  assign store_wdata_o = mem_req_write_data_i.mem_req_w_data;
  assign store_be_o    = mem_req_write_data_i.mem_req_w_be;
  assign dbg_state_o   = state_q;

  // Beat counter simply wraps; termination is driven by mem_req_w_last only.
  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    resp_wdata = '0;
    resp_wdata.mem_resp_w_id        = id_q;
    resp_wdata.mem_resp_w_error     = (cmd_q == hpdcache_pkg::HPDCACHE_MEM_WRITE) ?
                                      hpdcache_pkg::HPDCACHE_MEM_RESP_OK :
                                      hpdcache_pkg::HPDCACHE_MEM_RESP_NOK;
    resp_wdata.mem_resp_w_is_atomic = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      id_q     <= '0;
      cmd_q    <= hpdcache_pkg::HPDCACHE_MEM_READ;
      atomic_q <= hpdcache_pkg::HPDCACHE_MEM_ATOMIC_ADD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (meta_fire) begin
            base_q   <= mem_req_write_i.mem_req_addr;
            id_q     <= mem_req_write_i.mem_req_id;
            cmd_q    <= mem_req_write_i.mem_req_command;
            atomic_q <= mem_req_write_i.mem_req_atomic;
            cnt_q    <= '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (flit_fire) begin
            cnt_q <= cnt_d;
            if (flit_last) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Request fields that do not influence the write path; the latched atomic
  // opcode is held only for visibility of the transaction in progress.
  logic unused_meta;
  assign unused_meta = ^{mem_req_write_i.mem_req_len, mem_req_write_i.mem_req_size,
                         mem_req_write_i.mem_req_cacheable, atomic_q};

  hpdcache_fifo_reg #(
    .FIFO_DEPTH  (RespFifoDepth),
    .FEEDTHROUGH (1'b0),
    .fifo_data_t (hpdcache_mem_resp_w_t)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .w_i     (flit_fire & flit_last),
    .wok_o   (fifo_wok),
    .wdata_i (resp_wdata),
    .r_i     (mem_resp_write_ready_i),
    .rok_o   (mem_resp_write_valid_o),
    .rdata_o (mem_resp_write_o)
  );

endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
module tb_hpdcache_mem_write_responder;
  import hpdcache_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                 req_valid, req_ready;
  hpdcache_mem_req_t    req;
  logic                 data_valid, data_ready;
  hpdcache_mem_req_w_t  wd;
  logic                 resp_valid, resp_ready;
  hpdcache_mem_resp_w_t resp;
  logic                 store_we, store_ready;
  logic [31:0]          store_addr;
  logic [63:0]          store_wdata;
  logic [7:0]           store_be;
  logic                 dbg_state;

  hpdcache_mem_write_responder #(.RespFifoDepth(DEPTH)) dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_ni),
    .mem_req_write_valid_i      (req_valid),
    .mem_req_write_ready_o      (req_ready),
    .mem_req_write_i            (req),
    .mem_req_write_data_valid_i (data_valid),
    .mem_req_write_data_ready_o (data_ready),
    .mem_req_write_data_i       (wd),
    .mem_resp_write_valid_o     (resp_valid),
    .mem_resp_write_ready_i     (resp_ready),
    .mem_resp_write_o           (resp),
    .store_we_o                 (store_we),
    .store_ready_i              (store_ready),
    .store_addr_o               (store_addr),
    .store_wdata_o              (store_wdata),
    .store_be_o                 (store_be),
    .dbg_state_o                (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one open request plus an ordered list of
  // responses owed to the requester, bounded by the queue depth.
  typedef struct {
    logic [3:0] id;
    logic [1:0] err;
  } resp_t;
  resp_t       exp_q[$];
  logic        m_busy = 1'b0;
  logic [31:0] m_base = '0;
  logic [3:0]  m_id = '0;
  hpdcache_mem_command_e m_cmd = HPDCACHE_MEM_READ;
  int unsigned m_beat = 0;

  // Logs of what the DUT actually did, checked against literals per test.
  logic [31:0] wr_log[$];
  logic [3:0]  rid_log[$];
  logic [1:0]  rerr_log[$];
  int          rcyc_log[$];

  // ---------------- compare process ----------------
  initial begin
    logic  e_dr, e_we, e_rv;
    logic [31:0] e_addr;
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_beat = 0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_store_we", store_we, 0);
      end else begin
        e_dr = m_busy && store_ready && (!wd.mem_req_w_last || exp_q.size() < DEPTH);
        e_we = e_dr && data_valid && (m_cmd == HPDCACHE_MEM_WRITE);
        e_rv = exp_q.size() > 0;
        chk("req_ready", req_ready, !m_busy);
        chk("data_ready", data_ready, e_dr);
        chk("store_we", store_we, e_we);
        chk("resp_valid", resp_valid, e_rv);
        chk("dbg_state", dbg_state, m_busy);
        if (e_we) begin
          e_addr = m_base + 32'(m_beat * 8);
          chk("store_addr", store_addr, e_addr);
          chk("store_wdata", store_wdata, wd.mem_req_w_data);
          chk("store_be", store_be, wd.mem_req_w_be);
        end
        if (e_rv) begin
          chk("resp_id", resp.mem_resp_w_id, exp_q[0].id);
          chk("resp_err", resp.mem_resp_w_error, exp_q[0].err);
          chk("resp_atomic", resp.mem_resp_w_is_atomic, 0);
        end
        if (store_we) wr_log.push_back(store_addr);
        if (resp_valid && resp_ready) begin
          rid_log.push_back(resp.mem_resp_w_id);
          rerr_log.push_back(resp.mem_resp_w_error);
          rcyc_log.push_back(cyc);
        end
        // advance the model across the coming edge
        if (e_rv && resp_ready) void'(exp_q.pop_front());
        if (!m_busy && req_valid) begin
          m_busy = 1'b1;
          m_base = req.mem_req_addr;
          m_id   = req.mem_req_id;
          m_cmd  = req.mem_req_command;
          m_beat = 0;
        end else if (e_dr && data_valid) begin
          m_beat++;
          if (wd.mem_req_w_last) begin
            r.id  = m_id;
            r.err = (m_cmd == HPDCACHE_MEM_WRITE) ? HPDCACHE_MEM_RESP_OK : HPDCACHE_MEM_RESP_NOK;
            exp_q.push_back(r);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int fire_cyc, first_fire, last_fire;
  logic c_done;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rid_log.delete();
    rerr_log.delete();
    rcyc_log.delete();
  endtask

  task automatic send_meta(input logic [31:0] addr, input logic [3:0] id,
                           input hpdcache_mem_command_e cmd);
    int t;
    req = '0;
    req.mem_req_addr    = addr;
    req.mem_req_id      = id;
    req.mem_req_command = cmd;
    req.mem_req_len     = 8'd7;
    req.mem_req_size    = 3'd3;
    req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < LIMIT) begin @(negedge clk); t++; end
    chk($sformatf("meta_handshake_id%0d", id), t < LIMIT, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [63:0] d, input logic [7:0] be, input logic last);
    int t;
    wd.mem_req_w_data = d;
    wd.mem_req_w_be   = be;
    wd.mem_req_w_last = last;
    data_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!data_ready && t < LIMIT) begin @(negedge clk); t++; end
    chk("flit_handshake", t < LIMIT, 1);
    fire_cyc = cyc;
    @(posedge clk); #1;
    data_valid = 1'b0;
    wd.mem_req_w_last = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [63:0] dbase, input logic [7:0] be);
    for (int i = 0; i < n; i++) begin
      send_flit(dbase + 64'(i), be, i == n - 1);
      if (i == 0) first_fire = fire_cyc;
    end
    last_fire = fire_cyc;
  endtask

  task automatic chk_writes(input string tag, input logic [31:0] base, input int n);
    chk({tag, "_nwrites"}, wr_log.size(), n);
    for (int i = 0; i < wr_log.size() && i < n; i++)
      chk($sformatf("%s_addr%0d", tag, i), wr_log[i], base + 32'(i * 8));
  endtask

  // ---------------- stimulus ----------------
  logic burst_done;

  initial begin
    req_valid = 1'b0; req = '0;
    data_valid = 1'b0; wd = '0;
    resp_ready = 1'b1; store_ready = 1'b1;
    tick(3);
    rst_ni = 1'b1;
    tick(1);
    chk("init_req_ready", req_ready, 1);
    chk("init_data_ready", data_ready, 0);
    chk("init_resp_valid", resp_valid, 0);

    // T1: 8-flit WRITE at 0x1000, id 3
    clear_logs();
    send_meta(32'h1000, 4'd3, HPDCACHE_MEM_WRITE);
    send_burst(8, 64'hDEAD_0000_0000_0000, 8'hFF);
    tick(3);
    chk_writes("t1", 32'h1000, 8);
    chk("t1_nresp", rid_log.size(), 1);
    if (rid_log.size() > 0) begin
      chk("t1_resp_id", rid_log[0], 3);
      chk("t1_resp_err", rerr_log[0], HPDCACHE_MEM_RESP_OK);
      chk("t1_resp_latency", rcyc_log[0], last_fire + 1);
    end

    // T2: responses held, queue fills, third last flit stalls
    clear_logs();
    resp_ready = 1'b0;
    send_meta(32'h2000, 4'd0, HPDCACHE_MEM_WRITE);
    send_burst(2, 64'h20, 8'h0F);
    send_meta(32'h3000, 4'd1, HPDCACHE_MEM_WRITE);
    send_burst(2, 64'h30, 8'hF0);
    send_meta(32'h4000, 4'd2, HPDCACHE_MEM_WRITE);
    c_done = 1'b0;
    fork
      begin
        send_burst(2, 64'h40, 8'hFF);
        c_done = 1'b1;
      end
      begin
        tick(8);
        chk("t2_third_stalled", c_done, 0);
        resp_ready = 1'b1;
      end
    join
    tick(4);
    chk("t2_nresp", rid_log.size(), 3);
    for (int i = 0; i < rid_log.size() && i < 3; i++)
      chk($sformatf("t2_resp_order%0d", i), rid_log[i], i);
    chk("t2_nwrites", wr_log.size(), 6);

    // T3: store_ready toggling every cycle
    clear_logs();
    send_meta(32'h5000, 4'd4, HPDCACHE_MEM_WRITE);
    burst_done = 1'b0;
    fork
      begin
        send_burst(8, 64'h5500, 8'hFF);
        burst_done = 1'b1;
      end
      begin
        while (!burst_done) begin
          @(posedge clk); #1;
          store_ready = ~store_ready;
        end
      end
    join
    store_ready = 1'b1;
    tick(3);
    chk_writes("t3", 32'h5000, 8);
    chk("t3_span", last_fire - first_fire, 14);

    // T4: non-WRITE command
    clear_logs();
    send_meta(32'h6000, 4'd5, HPDCACHE_MEM_READ);
    send_burst(2, 64'h66, 8'hFF);
    tick(3);
    chk("t4_nwrites", wr_log.size(), 0);
    chk("t4_nresp", rid_log.size(), 1);
    if (rid_log.size() > 0) begin
      chk("t4_resp_id", rid_log[0], 5);
      chk("t4_resp_err", rerr_log[0], HPDCACHE_MEM_RESP_NOK);
    end

    // T5: flit presented before its metadata
    clear_logs();
    wd.mem_req_w_data = 64'h77; wd.mem_req_w_be = 8'h3C; wd.mem_req_w_last = 1'b1;
    data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_idle_data_ready", data_ready, 0);
    end
    tick(1);
    send_meta(32'h7700, 4'd6, HPDCACHE_MEM_WRITE);
    send_flit(64'h77, 8'h3C, 1'b1);
    tick(3);
    chk_writes("t5", 32'h7700, 1);
    chk("t5_nresp", rid_log.size(), 1);
    if (rid_log.size() > 0) chk("t5_resp_id", rid_log[0], 6);

    // T6: reset after 3 of 8 flits, then a clean transaction
    clear_logs();
    send_meta(32'h7000, 4'd7, HPDCACHE_MEM_WRITE);
    for (int i = 0; i < 3; i++) send_flit(64'h70 + 64'(i), 8'hFF, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("t6_async_req_ready", req_ready, 1);
    chk("t6_async_data_ready", data_ready, 0);
    tick(2);
    rst_ni = 1'b1;
    tick(5);
    chk("t6_no_resp_after_reset", rid_log.size(), 0);
    send_meta(32'h8000, 4'd8, HPDCACHE_MEM_WRITE);
    send_burst(2, 64'h80, 8'hFF);
    tick(3);
    chk("t6_nwrites", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      chk("t6_addr3", wr_log[3], 32'h8000);
      chk("t6_addr4", wr_log[4], 32'h8008);
    end
    chk("t6_nresp", rid_log.size(), 1);
    if (rid_log.size() > 0) chk("t6_resp_id", rid_log[0], 8);

    // T7: address wraps modulo the address width
    clear_logs();
    send_meta(32'hFFFF_FFF8, 4'd9, HPDCACHE_MEM_WRITE);
    send_burst(2, 64'h99, 8'hFF);
    tick(3);
    chk("t7_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t7_addr0", wr_log[0], 32'hFFFF_FFF8);
      chk("t7_addr1", wr_log[1], 32'h0000_0000);
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hpdcache_mem_write_responder.md
HPDCACHE_MEM_WRITE_RESPONDER -- requirements
Module: hpdcache_mem_write_responder

Interface
REQ-001 SHALL have parameter HPDcacheCfg, default '0, cache configuration; uses u.memDataWidth and memory address width.
REQ-002 SHALL have type parameters hpdcache_mem_id_t, hpdcache_mem_req_t, hpdcache_mem_req_w_t, hpdcache_mem_resp_w_t, default logic, memory-interface payload types.
REQ-003 SHALL have parameter RespFifoDepth, default 2, number of response FIFO entries.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 mem_req_write_valid_i / mem_req_write_ready_o / mem_req_write_i  in/out/in  1/1/hpdcache_mem_req_t  write request metadata channel.
REQ-007 mem_req_write_data_valid_i / mem_req_write_data_ready_o / mem_req_write_data_i  in/out/in  1/1/hpdcache_mem_req_w_t  write data flit channel.
REQ-008 mem_resp_write_valid_o / mem_resp_write_ready_i / mem_resp_write_o  out/in/out  1/1/hpdcache_mem_resp_w_t  write response channel.
REQ-009 store_we_o / store_ready_i  out/in  1/1  backing-store write strobe and acceptance.
REQ-010 store_addr_o / store_wdata_o / store_be_o  out  addr width / memDataWidth / memDataWidth/8  byte address, data, byte enables of current flit.

Function
REQ-011 FSM states: IDLE, DATA.
REQ-012 IDLE: mem_req_write_ready_o=1; on valid&ready latch addr, id, command, atomic; clear beat counter; go to DATA.
REQ-013 DATA: mem_req_write_ready_o=0; mem_req_write_data_ready_o = store_ready_i & (~last | resp_fifo_wok).
REQ-014 IDLE: mem_req_write_data_ready_o=0; flits never accepted before their metadata.
REQ-015 Flit accept (valid&ready): store_we_o=1 same cycle, only when latched command is HPDCACHE_MEM_WRITE.
REQ-016 On flit accept: store_addr_o = base + counter*(memDataWidth/8), modulo address width; store_wdata_o/store_be_o = flit data/be, passed through combinationally.
REQ-017 Beat counter increments per accepted flit and wraps at its width without error.
REQ-018 Transaction ends on an accepted flit with mem_req_w_last=1; mem_req_len is not used for termination.
REQ-019 End of transaction: push response {id=latched id, error=OK for WRITE else NOK, is_atomic=0} into FIFO; return to IDLE same cycle.
REQ-020 Non-WRITE command: all flits consumed, store never written, response error=NOK.
REQ-021 Last flit with FIFO full: flit stalled (data ready=0) until FIFO slot frees; no response lost.
REQ-022 Response latency: mem_resp_write_valid_o asserted the cycle after the last-flit accept (non-feedthrough FIFO).
REQ-023 Responses returned in request order; mem_resp_write_o stable while valid & ~ready.
REQ-024 Next metadata accepted the cycle after last-flit accept (one idle bubble max).
REQ-025 store_ready_i=0 in DATA: no flit accepted, counter and state hold.

Reset
REQ-026 Reset: FSM=IDLE, counter=0, FIFO empty.
REQ-027 Output values in reset: mem_req_write_ready_o=1, data ready=0, mem_resp_write_valid_o=0, store_we_o=0.
REQ-028 Reset mid-transaction: in-flight transaction and queued responses discarded; no response emitted afterwards.

Structure
REQ-029 Memory request/response types, HPDCACHE_MEM_WRITE, response error encodings from hpdcache_pkg; no new package types.
REQ-030 Sub-module: hpdcache_fifo_reg (FIFO_DEPTH=RespFifoDepth, FEEDTHROUGH=0) as response queue; latched metadata is local flops.

Verification
REQ-031 memDataWidth=64, meta addr 0x1000 id 3 WRITE, 8 flits be='1, last on 8th -> store writes 0x1000..0x1038 step 8; resp id 3 OK one cycle after 8th flit.
REQ-032 Two back-to-back requests ids 0,1, mem_resp_write_ready_i=0 -> both queued; third last flit stalls; release ready -> ids 0,1 in order, then third completes.
REQ-033 store_ready_i toggling 1/0 every cycle -> 8 flits over 16 cycles, addresses contiguous, no duplicate/skipped writes.
REQ-034 Command non-WRITE, 2 flits -> store_we_o never 1; resp error NOK, correct id.
REQ-035 Flit valid while IDLE with no meta -> data ready stays 0; flit accepted only after meta.
REQ-036 Assert rst_ni after 3 of 8 flits -> ready/valid outputs at reset values; no response for aborted id; next transaction completes normally.
